// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: packet width and the
// branch-prediction sideband carried alongside each packet.
package fetch_pkg;

  localparam int FD_PKT_W      = 128;
  localparam int FD_SIDEBAND_W = 39;

  typedef struct packed {
    logic        is_BR_T_NT;
    logic [31:0] BP_target;
    logic [5:0]  BP_update_alias;
  } fd_sideband_t;

endpackage

// File: rtl/fd_queue_ram.sv
// Register array behind the fetch/decode queue:
// one synchronous write port, one asynchronous read port.
module fd_queue_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 167,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fd_packet_queue.sv
// FWFT queue between fetch_2 and decode, with early
// stall for in-flight packets and flush on resteer.
module fd_packet_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SKID  = 1,
  parameter int PKT_W = FD_PKT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PKT_W-1:0]           packet_in,
  input  logic                       packet_valid_in,
  input  logic                       is_BR_T_NT_in,
  input  logic [31:0]                BP_target_in,
  input  logic [5:0]                 BP_update_alias_in,
  input  logic                       resteer,
  input  logic                       dec_ready,
  output logic [PKT_W-1:0]           packet_out,
  output logic                       packet_valid_out,
  output logic                       is_BR_T_NT_out,
  output logic [31:0]                BP_target_out,
  output logic [5:0]                 BP_update_alias_out,
  output logic                       stall_out,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PKT_W + FD_SIDEBAND_W;

  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - SKID);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  fd_sideband_t  sb_in;
  fd_sideband_t  sb_out;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;

  logic empty;
  logic full;
  logic deq;
  logic enq;
  logic ovf;

  assign empty = (count == '0);
  assign full  = (count == FULL);

  // A full queue still accepts when the head leaves
  // in the same cycle.
  assign deq = dec_ready & ~empty;
  assign enq = packet_valid_in & ~resteer
             & (~full | deq);
  assign ovf = packet_valid_in & ~resteer
             & full & ~deq;

  assign sb_in.is_BR_T_NT      = is_BR_T_NT_in;
  assign sb_in.BP_target       = BP_target_in;
  assign sb_in.BP_update_alias = BP_update_alias_in;
  assign wdata = {packet_in, sb_in};

  fd_queue_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign {packet_out, sb_out} = rdata;
  assign is_BR_T_NT_out       = sb_out.is_BR_T_NT;
  assign BP_target_out        = sb_out.BP_target;
  assign BP_update_alias_out  = sb_out.BP_update_alias;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (resteer) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // Sticky until reset; resteer deliberately leaves it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_err <= 1'b0;
    end else if (ovf) begin
      overflow_err <= 1'b1;
    end
  end

  assign packet_valid_out = ~empty;
  assign stall_out        = (count >= STALL_AT);
  assign count_out        = count;

endmodule

// File: tb/tb_fd_packet_queue.sv
// Randomized and directed bench for fd_packet_queue,
// checked against a queue-based reference model.
module tb_fd_packet_queue;

  localparam int DEPTH = 4;
  localparam int SKID  = 1;
  localparam int PKT_W = 128;

  typedef struct {
    logic [PKT_W-1:0] p;
    logic             br;
    logic [31:0]      t;
    logic [5:0]       a;
  } ent_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [PKT_W-1:0] packet_in = '0;
  logic             packet_valid_in = 1'b0;
  logic             is_BR_T_NT_in = 1'b0;
  logic [31:0]      BP_target_in = '0;
  logic [5:0]       BP_update_alias_in = '0;
  logic             resteer = 1'b0;
  logic             dec_ready = 1'b0;
  logic [PKT_W-1:0] packet_out;
  logic             packet_valid_out;
  logic             is_BR_T_NT_out;
  logic [31:0]      BP_target_out;
  logic [5:0]       BP_update_alias_out;
  logic             stall_out;
  logic [2:0]       count_out;
  logic             overflow_err;

  int tests = 0;
  int fails = 0;

  ent_t mq[$];
  bit   mov = 1'b0;

  always #5 clk = ~clk;

  fd_packet_queue #(
    .DEPTH (DEPTH),
    .SKID  (SKID),
    .PKT_W (PKT_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .packet_in           (packet_in),
    .packet_valid_in     (packet_valid_in),
    .is_BR_T_NT_in       (is_BR_T_NT_in),
    .BP_target_in        (BP_target_in),
    .BP_update_alias_in  (BP_update_alias_in),
    .resteer             (resteer),
    .dec_ready           (dec_ready),
    .packet_out          (packet_out),
    .packet_valid_out    (packet_valid_out),
    .is_BR_T_NT_out      (is_BR_T_NT_out),
    .BP_target_out       (BP_target_out),
    .BP_update_alias_out (BP_update_alias_out),
    .stall_out           (stall_out),
    .count_out           (count_out),
    .overflow_err        (overflow_err)
  );

  function automatic ent_t mk(input logic [7:0] v);
    ent_t e;
    e.p  = {16{v}};
    e.br = v[0];
    e.t  = 32'h1000_0000 + {22'd0, v, 2'b00};
    e.a  = v[5:0];
    return e;
  endfunction

  function automatic ent_t rnd();
    ent_t e;
    e.p  = {$urandom, $urandom, $urandom, $urandom};
    e.br = 1'($urandom);
    e.t  = $urandom;
    e.a  = 6'($urandom);
    return e;
  endfunction

  // Called at a falling edge; returns at the next one.
  task automatic step(input bit v, input ent_t e,
                      input bit rs, input bit dr);
    bit d;
    bit acc;
    packet_valid_in    = v;
    packet_in          = e.p;
    is_BR_T_NT_in      = e.br;
    BP_target_in       = e.t;
    BP_update_alias_in = e.a;
    resteer            = rs;
    dec_ready          = dr;
    @(posedge clk);
    if (rs) begin
      mq.delete();
    end else begin
      d   = dr && mq.size() != 0;
      acc = v && (mq.size() < DEPTH || d);
      if (v && !acc) mov = 1'b1;
      if (d) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    ent_t z;
    z = mk(8'h00);
    for (int i = 0; i < n; i++) step(1'b0, z, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (packet_valid_out !== 1'b0 || count_out !== 3'd0 ||
        stall_out !== 1'b0 || overflow_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: v=%b c=%0d s=%b o=%b want 0",
               packet_valid_out, count_out, stall_out,
               overflow_err);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    tests++;
    if (packet_valid_out !== 1'b0 || count_out !== 3'd0 ||
        stall_out !== 1'b0 || overflow_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: v=%b c=%0d s=%b o=%b want 0",
               packet_valid_out, count_out, stall_out,
               overflow_err);
    end
  endtask

  task automatic test_fill();
    ent_t e;
    for (int i = 0; i < 4; i++) begin
      e = mk(8'hA0 + 8'(i));
      step(1'b1, e, 1'b0, 1'b0);
      tests++;
      if (count_out !== 3'(i + 1)) begin
        fails++;
        $display("FAIL fill_count: got %0d want %0d",
                 count_out, i + 1);
      end
      tests++;
      if (stall_out !== (i + 1 >= DEPTH - SKID)) begin
        fails++;
        $display("FAIL fill_stall: got %b at count %0d",
                 stall_out, i + 1);
      end
      tests++;
      if (overflow_err !== 1'b0) begin
        fails++;
        $display("FAIL fill_ovf: got %b want 0", overflow_err);
      end
      tests++;
      if (packet_out !== mk(8'hA0).p ||
          packet_valid_out !== 1'b1) begin
        fails++;
        $display("FAIL fill_head: got %h v=%b want A0..",
                 packet_out[7:0], packet_valid_out);
      end
    end
  endtask

  task automatic test_drain(input logic [7:0] first);
    ent_t e;
    ent_t z;
    z = mk(8'h00);
    for (int i = 0; i < 4; i++) begin
      e = mk(first + 8'(i));
      tests++;
      if (packet_out !== e.p || BP_target_out !== e.t ||
          BP_update_alias_out !== e.a ||
          is_BR_T_NT_out !== e.br) begin
        fails++;
        $display("FAIL drain_head%0d: got %h/%h want %h/%h",
                 i, packet_out[7:0], BP_target_out,
                 e.p[7:0], e.t);
      end
      step(1'b0, z, 1'b0, 1'b1);
      tests++;
      if (count_out !== 3'(3 - i) ||
          stall_out !== (3 - i >= DEPTH - SKID)) begin
        fails++;
        $display("FAIL drain_cnt%0d: got c=%0d s=%b want c=%0d",
                 i, count_out, stall_out, 3 - i);
      end
    end
    tests++;
    if (packet_valid_out !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty: got valid %b want 0",
               packet_valid_out);
    end
  endtask

  task automatic test_full_enq_deq();
    ent_t z;
    z = mk(8'h00);
    for (int i = 0; i < 4; i++)
      step(1'b1, mk(8'hA0 + 8'(i)), 1'b0, 1'b0);
    step(1'b1, mk(8'hB0), 1'b0, 1'b1);
    tests++;
    if (count_out !== 3'd4 || overflow_err !== 1'b0) begin
      fails++;
      $display("FAIL full_swap: got c=%0d o=%b want 4/0",
               count_out, overflow_err);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (packet_out !== (i < 3 ? mk(8'hA1 + 8'(i)).p
                                : mk(8'hB0).p)) begin
        fails++;
        $display("FAIL full_swap_head%0d: got %h", i,
                 packet_out[7:0]);
      end
      step(1'b0, z, 1'b0, 1'b1);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++)
      step(1'b1, mk(8'hD0 + 8'(i)), 1'b0, 1'b0);
    step(1'b1, mk(8'hEE), 1'b0, 1'b0);
    tests++;
    if (overflow_err !== 1'b1 || count_out !== 3'd4) begin
      fails++;
      $display("FAIL overflow: got o=%b c=%0d want 1/4",
               overflow_err, count_out);
    end
    test_drain(8'hD0);
    tests++;
    if (overflow_err !== 1'b1) begin
      fails++;
      $display("FAIL overflow_sticky: got %b want 1",
               overflow_err);
    end
  endtask

  task automatic test_resteer();
    step(1'b1, mk(8'hE0), 1'b0, 1'b0);
    step(1'b1, mk(8'hE1), 1'b0, 1'b0);
    step(1'b1, mk(8'hF0), 1'b1, 1'b1);
    tests++;
    if (count_out !== 3'd0 || packet_valid_out !== 1'b0 ||
        stall_out !== 1'b0) begin
      fails++;
      $display("FAIL resteer: got c=%0d v=%b s=%b want 0",
               count_out, packet_valid_out, stall_out);
    end
    step(1'b1, mk(8'hC0), 1'b0, 1'b0);
    tests++;
    if (packet_out !== mk(8'hC0).p || count_out !== 3'd1 ||
        overflow_err !== 1'b1) begin
      fails++;
      $display("FAIL resteer_next: got %h c=%0d o=%b want C0/1/1",
               packet_out[7:0], count_out, overflow_err);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, mk(8'h41), 1'b0, 1'b0);
    step(1'b1, mk(8'h42), 1'b0, 1'b0);
    tests++;
    if (count_out !== 3'd3) begin
      fails++;
      $display("FAIL areset_pre: got c=%0d want 3", count_out);
    end
    packet_valid_in = 1'b0;
    dec_ready       = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (packet_valid_out !== 1'b0 || count_out !== 3'd0 ||
        stall_out !== 1'b0 || overflow_err !== 1'b0) begin
      fails++;
      $display("FAIL areset_now: v=%b c=%0d s=%b o=%b want 0",
               packet_valid_out, count_out, stall_out,
               overflow_err);
    end
    mq.delete();
    mov = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, mk(8'h51), 1'b0, 1'b0);
    step(1'b1, mk(8'h52), 1'b0, 1'b0);
    tests++;
    if (packet_out !== mk(8'h51).p || count_out !== 3'd2) begin
      fails++;
      $display("FAIL areset_after: got %h c=%0d want 51/2",
               packet_out[7:0], count_out);
    end
  endtask

  task automatic test_random();
    ent_t e;
    int   bias;
    bit   v;
    bit   rs;
    bit   dr;
    for (int n = 0; n < 360; n++) begin
      bias = (n / 60) % 3;
      v    = $urandom_range(0, 3) != 0;
      rs   = $urandom_range(0, 19) == 0;
      dr   = $urandom_range(0, 3) < bias;
      e    = rnd();
      step(v, e, rs, dr);
      tests++;
      if (count_out !== 3'(mq.size()) ||
          packet_valid_out !== (mq.size() != 0) ||
          stall_out !== (mq.size() >= DEPTH - SKID) ||
          overflow_err !== mov) begin
        fails++;
        $display("FAIL rand_state%0d: c=%0d v=%b s=%b o=%b want c=%0d o=%b",
                 n, count_out, packet_valid_out, stall_out,
                 overflow_err, mq.size(), mov);
      end
      if (mq.size() != 0) begin
        tests++;
        if (packet_out !== mq[0].p ||
            BP_target_out !== mq[0].t ||
            BP_update_alias_out !== mq[0].a ||
            is_BR_T_NT_out !== mq[0].br) begin
          fails++;
          $display("FAIL rand_head%0d: got %h/%h want %h/%h",
                   n, packet_out[31:0], BP_target_out,
                   mq[0].p[31:0], mq[0].t);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain(8'hA0);
    test_full_enq_deq();
    test_overflow();
    test_resteer();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
